// File: rtl/game_ctrl.sv
// Breakout game sequencer: serve/play/pause flow, lives, level and saturating score.
// Every output is registered; ball_rst and paddle_en are decoded from the next state.
module game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LEVELS       = 3,
    parameter int unsigned DELAY_CYCLES = 50_000_000,
    parameter int unsigned SCORE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        ball_lose,
    input  logic        ball_win,
    input  logic        brick_hit,
    output logic        ball_rst,
    output logic        wall_reload,
    output logic        paddle_en,
    output logic [2:0]  lives,
    output logic [2:0]  level,
    output logic [13:0] score,
    output logic [2:0]  state
);

    localparam int unsigned TW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          start_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    lives_q, lives_d;
    logic [2:0]    level_q, level_d;
    logic [13:0]   score_q, score_d;
    logic          ball_rst_q, ball_rst_d;
    logic          wall_reload_q, wall_reload_d;
    logic          paddle_en_q, paddle_en_d;

    logic          start_edge;
    logic          timer_last;
    logic [14:0]   score_sum;

    always_comb begin
        start_edge    = start_btn & ~start_q;
        timer_last    = (timer_q == TW'(DELAY_CYCLES - 1));
        score_sum     = {1'b0, score_q} + {12'b0, level_q};

        state_d       = state_q;
        lives_d       = lives_q;
        level_d       = level_q;
        score_d       = score_q;
        wall_reload_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER, S_DONE: begin
                if (start_edge) begin
                    lives_d       = 3'(LIVES);
                    level_d       = 3'd1;
                    score_d       = '0;
                    wall_reload_d = 1'b1;
                    state_d       = S_SERVE;
                end
            end
            S_SERVE: begin
                if (start_edge) state_d = S_PLAY;
            end
            S_PLAY: begin
                // Hits are scored even on the cycle that leaves PLAY.
                if (brick_hit) begin
                    if (score_sum > 15'(SCORE_MAX)) score_d = 14'(SCORE_MAX);
                    else                            score_d = score_sum[13:0];
                end
                if (ball_win) begin
                    state_d = S_CLEAR;
                end else if (ball_lose) begin
                    if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                if (timer_last) state_d = (lives_q == 3'd0) ? S_OVER : S_SERVE;
            end
            S_CLEAR: begin
                if (timer_last) begin
                    if (level_q == 3'(LEVELS)) begin
                        state_d = S_DONE;
                    end else begin
                        level_d       = level_q + 3'd1;
                        wall_reload_d = 1'b1;
                        state_d       = S_SERVE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == S_MISS || state_q == S_CLEAR)
            timer_d = timer_q + 1'b1;
        else
            timer_d = '0;

        ball_rst_d  = (state_d != S_PLAY);
        paddle_en_d = (state_d inside {S_SERVE, S_PLAY, S_MISS, S_CLEAR});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            timer_q       <= '0;
            lives_q       <= 3'(LIVES);
            level_q       <= 3'd1;
            score_q       <= '0;
            ball_rst_q    <= 1'b1;
            wall_reload_q <= 1'b0;
            paddle_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_btn;
            timer_q       <= timer_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            score_q       <= score_d;
            ball_rst_q    <= ball_rst_d;
            wall_reload_q <= wall_reload_d;
            paddle_en_q   <= paddle_en_d;
        end
    end

    assign ball_rst    = ball_rst_q;
    assign wall_reload = wall_reload_q;
    assign paddle_en   = paddle_en_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign score       = score_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game flow then random play, every cycle compared
// against a phase/countdown reference model of the game rules.
module tb_game_ctrl;

    localparam int M_LIVES  = 3;
    localparam int M_LEVELS = 3;
    localparam int M_DELAY  = 4;
    localparam int M_SMAX   = 9999;

    logic        clk = 1'b0;
    logic        rst, start_btn, ball_lose, ball_win, brick_hit;
    logic        ball_rst, wall_reload, paddle_en;
    logic [2:0]  lives, level, state;
    logic [13:0] score;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number plus a remaining-cycles countdown for pauses.
    int m_phase, m_lives, m_level, m_score, m_left;
    bit m_reload, m_btn_prev;

    game_ctrl #(
        .LIVES(3), .LEVELS(3), .DELAY_CYCLES(4), .SCORE_MAX(9999)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .ball_lose(ball_lose),
        .ball_win(ball_win), .brick_hit(brick_hit), .ball_rst(ball_rst),
        .wall_reload(wall_reload), .paddle_en(paddle_en), .lives(lives),
        .level(level), .score(score), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit l, input bit w, input bit h);
        bit edge_seen;
        edge_seen  = s && !m_btn_prev;
        m_btn_prev = s;
        m_reload   = 0;
        if (!r) begin
            m_phase = 0; m_lives = M_LIVES; m_level = 1; m_score = 0; m_btn_prev = 0;
            return;
        end
        case (m_phase)
            0, 5, 6: if (edge_seen) begin
                m_lives = M_LIVES; m_level = 1; m_score = 0; m_reload = 1; m_phase = 1;
            end
            1: if (edge_seen) m_phase = 2;
            2: begin
                if (h) m_score = (m_score + m_level > M_SMAX) ? M_SMAX : m_score + m_level;
                if (w) begin
                    m_phase = 4; m_left = M_DELAY;
                end else if (l) begin
                    if (m_lives > 0) m_lives--;
                    m_phase = 3; m_left = M_DELAY;
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) m_phase = (m_lives == 0) ? 5 : 1;
            end
            4: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_level == M_LEVELS) m_phase = 6;
                    else begin m_level++; m_reload = 1; m_phase = 1; end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic step(input bit r, input bit s, input bit l, input bit w, input bit h);
        rst = r; start_btn = s; ball_lose = l; ball_win = w; brick_hit = h;
        @(posedge clk);
        model(r, s, l, w, h);
        #1;
        chk("state", state, m_phase);
        chk("ball_rst", ball_rst, m_phase != 2);
        chk("paddle_en", paddle_en, m_phase >= 1 && m_phase <= 4);
        chk("wall_reload", wall_reload, m_reload);
        chk("lives", lives, m_lives);
        chk("level", level, m_level);
        chk("score", score, m_score);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic press();
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        m_phase = 0; m_lives = M_LIVES; m_level = 1; m_score = 0;
        m_left = 0; m_reload = 0; m_btn_prev = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(2);
        press();                         // IDLE -> SERVE with reload
        press();                         // SERVE -> PLAY
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        step(1, 0, 1, 1, 1);             // win beats lose, hit still scored
        for (int i = 0; i < M_DELAY + 3; i++) step(1, 1, 0, 0, 0);  // held button across CLEAR
        step(1, 0, 0, 0, 0);
        press();                         // PLAY at level 2
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0);
        idle(M_DELAY + 1);
        press();                         // PLAY at level 3
        for (int i = 0; i < 3400; i++) step(1, 0, 0, 0, 1);  // drives score into saturation
        for (int k = 0; k < M_LIVES; k++) begin
            step(1, 0, 1, 0, 0);
            idle(M_DELAY + 1);
            press();
        end
        idle(2);                         // OVER: presses after the last miss restarted
        press();
        press();
        step(1, 0, 0, 1, 0);
        idle(M_DELAY + 1);
        press();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0);             // CLEAR at level 2
        idle(M_DELAY + 1);
        press();
        step(1, 0, 0, 1, 0);             // level 3 win -> DONE
        idle(M_DELAY + 2);
        press();
        press();
        step(1, 0, 1, 0, 0);             // MISS
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);             // reset in second MISS cycle
        idle(3);

        for (int i = 0; i < 20000; i++) begin
            bit s;
            s = ($urandom % 6 == 0) ? !start_btn : start_btn;
            step(($urandom % 700) != 0, s, ($urandom % 25) == 0,
                 ($urandom % 30) == 0, ($urandom % 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
